sha256_round_driver: RTL and testbench

Master-side driver for the SHA compression round datapath. It accepts a 512-bit message block as 16 word-serial 32-bit words and holds the chaining state H0..H7. It drives the round datapath for 64 single-cycle rounds with W_t (16-entry circular message schedule) and K_t (constant ROM). It then adds the round result into H and presents the digest. Scope is SHA-224/SHA-256 only; the 64-bit modes are rejected.

---
 rtl/sha256_round_driver_if.sv | 45 ++++
 rtl/sha256_round_driver.sv | 158 +++++++++++++++
 tb/tb_sha256_round_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_driver_if.sv
// Mode encoding shared by the driver and the round datapath, plus the bundle
// of handshake and datapath signals between the driver, its message source,
// the round datapath and the digest consumer.
package sha;
  typedef enum logic [1:0] {
    sha224 = 2'd0,
    sha256 = 2'd1,
    sha384 = 2'd2,
    sha512 = 2'd3
  } mode_t;
endpackage

interface sha256_round_driver_if;
  logic           start;
  logic           init;
  sha::mode_t     mode;
  logic           err;
  logic           busy;
  logic           msg_valid;
  logic           msg_ready;
  logic [31:0]    msg_data;
  sha::mode_t     ml_mode;
  logic           ml_enable;
  logic [31:0]    ml_w;
  logic [31:0]    ml_k;
  logic [255:0]   ml_raw;
  logic [255:0]   ml_ripe;
  logic           digest_valid;
  logic           digest_ready;
  logic [255:0]   digest;

  // Driver side
  modport master (
    input  start, init, mode, msg_valid, msg_data, ml_ripe, digest_ready,
    output err, busy, msg_ready, ml_mode, ml_enable, ml_w, ml_k, ml_raw,
           digest_valid, digest
  );

  // Environment side (message source, round datapath, digest sink)
  modport slave (
    output start, init, mode, msg_valid, msg_data, ml_ripe, digest_ready,
    input  err, busy, msg_ready, ml_mode, ml_enable, ml_w, ml_k, ml_raw,
           digest_valid, digest
  );
endinterface

// File: rtl/sha256_round_driver.sv
// SHA-224/SHA-256 round driver: collects a 16-word block, sequences 64
// single-cycle rounds through an external round datapath using a circular
// message schedule, folds the result into the chaining state and presents
// the digest.
module sha256_round_driver (
  input  logic                   clk,
  input  logic                   rstn,
  sha256_round_driver_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  state_t       state;
  logic [5:0]   t;            // word index in LOAD, round index in ROUND
  logic [31:0]  h [8];
  logic [31:0]  msg_buf [16];
  sha::mode_t   mode_q;
  logic         err_q;
  logic         busy_q;
  logic         ready_q;
  logic         enable_q;
  logic         dvalid_q;
  logic [3:0]   ti;
  logic [31:0]  w_cur;
  logic [255:0] h_flat;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign ti = t[3:0];

  // W_t: raw block word for the first 16 rounds, schedule expansion after
  always_comb begin
    w_cur = msg_buf[ti];
    if (t[5:4] != 2'b00) begin
      w_cur = sig1(msg_buf[ti + 4'd14]) + msg_buf[ti + 4'd9]
            + sig0(msg_buf[ti + 4'd1]) + msg_buf[ti];
    end
  end

  // Flatten H with H0 in the most significant lane
  always_comb begin
    h_flat = '0;
    for (int i = 0; i < 8; i++) h_flat[32*(7-i) +: 32] = h[i];
  end

  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.msg_ready    = ready_q;
  assign bus.ml_mode      = mode_q;
  assign bus.ml_enable    = enable_q;
  assign bus.digest_valid = dvalid_q;
  assign bus.ml_w         = (state == ROUND) ? w_cur : 32'h0;
  assign bus.ml_k         = (state == ROUND) ? K_ROM[t] : 32'h0;
  assign bus.ml_raw       = (state == ROUND && t != 6'd0) ? bus.ml_ripe : h_flat;
  assign bus.digest       = {h_flat[255:32], (mode_q == sha::sha224) ? 32'h0 : h_flat[31:0]};

  // Block sequencer: IDLE -> LOAD -> ROUND -> FINAL -> OUT -> IDLE
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      t        <= '0;
      mode_q   <= sha::sha256;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      dvalid_q <= 1'b0;
      for (int i = 0; i < 8; i++)  h[i]       <= '0;
      for (int i = 0; i < 16; i++) msg_buf[i] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.mode == sha::sha224 || bus.mode == sha::sha256) begin
              mode_q <= bus.mode;
              if (bus.init) begin
                for (int i = 0; i < 8; i++)
                  h[i] <= (bus.mode == sha::sha224) ? IV224[i] : IV256[i];
              end
              t       <= '0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
              state   <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.msg_valid) begin
            msg_buf[ti] <= bus.msg_data;
            if (t == 6'd15) begin
              t        <= '0;
              ready_q  <= 1'b0;
              enable_q <= 1'b1;
              state    <= ROUND;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        ROUND: begin
          // Rounds 0..15 rewrite the word already held; later rounds retire W_{t-16}
          msg_buf[ti] <= w_cur;
          if (t == 6'd63) begin
            t        <= '0;
            enable_q <= 1'b0;
            state    <= FINAL;
          end else begin
            t <= t + 6'd1;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + bus.ml_ripe[32*(7-i) +: 32];
          dvalid_q <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (bus.digest_ready) begin
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_driver.sv
// Bench for sha256_round_driver: emulates the round datapath, feeds blocks with
// random gaps and backpressure, and compares digests with known vectors and a
// full-schedule SHA-256 compression model.
`timescale 1ns/1ps
module tb_sha256_round_driver;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sha256_round_driver_if bus();
  sha256_round_driver dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Round datapath stand-in: registered result, updates only on enabled edges
  logic [255:0] ripe_q = '0;
  assign bus.ml_ripe = ripe_q;
  always @(posedge clk) if (bus.ml_enable) ripe_q <= round_fn(bus.ml_raw, bus.ml_w, bus.ml_k);

  // Reference model state
  logic [31:0] mh [8];
  logic [31:0] blk [16];

  task automatic model_block(input sha::mode_t m, input bit ini);
    logic [31:0] w [64];
    logic [255:0] s;
    if (ini) for (int i = 0; i < 8; i++) mh[i] = (m == sha::sha224) ? IV224[i] : IV256[i];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    s = {mh[0], mh[1], mh[2], mh[3], mh[4], mh[5], mh[6], mh[7]};
    for (int i = 0; i < 64; i++) s = round_fn(s, w[i], KT[i]);
    for (int i = 0; i < 8; i++) mh[i] = mh[i] + s[255 - 32*i -: 32];
  endtask

  function automatic logic [255:0] model_digest(input sha::mode_t m);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255 - 32*i -: 32] = mh[i];
    if (m == sha::sha224) d[31:0] = 32'h0;
    return d;
  endfunction

  task automatic set_abc();
    foreach (blk[i]) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic do_start(input sha::mode_t m, input bit ini);
    @(negedge clk);
    bus.start = 1'b1; bus.init = ini; bus.mode = m;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Feeds blk with random gaps, then measures edges from last word to digest_valid
  task automatic send_block(input int gap, output int lat, output int en_cnt);
    int k = 0;
    int cyc = 0;
    bit v, rdy;
    while (k < 16 && cyc < 5000) begin
      @(negedge clk);
      v = ($urandom_range(0, 99) >= gap);
      bus.msg_valid = v;
      bus.msg_data = blk[k];
      rdy = bus.msg_ready;
      @(posedge clk);
      if (v && rdy) k++;
      cyc++;
    end
    lat = 0;
    en_cnt = 0;
    @(negedge clk);
    bus.msg_valid = 1'b0;
    while (!bus.digest_valid && lat < 300) begin
      if (bus.ml_enable) en_cnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic recv_digest(input int bp, output logic [255:0] got, output bit stable);
    int n = 0;
    while (!bus.digest_valid && n < 300) begin @(negedge clk); n++; end
    got = bus.digest;
    stable = 1'b1;
    repeat (bp) begin
      @(negedge clk);
      if (bus.digest !== got || bus.digest_valid !== 1'b1) stable = 1'b0;
    end
    @(negedge clk);
    if (bus.digest !== got) stable = 1'b0;
    bus.digest_ready = 1'b1;
    @(posedge clk);
    #1 bus.digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.msg_valid = 1'b1;
    bus.digest_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.err, bus.busy, bus.msg_ready, bus.ml_enable, bus.digest_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.err, bus.busy, bus.msg_ready, bus.ml_enable, bus.digest_valid}); end
    checks++; if (bus.digest !== 256'h0) begin errors++; $display("FAIL reset_digest got=%h exp=0", bus.digest); end
    checks++; if (bus.ml_w !== 32'h0) begin errors++; $display("FAIL reset_ml_w got=%h exp=0", bus.ml_w); end
    checks++; if (bus.ml_k !== 32'h0) begin errors++; $display("FAIL reset_ml_k got=%h exp=0", bus.ml_k); end
    checks++; if (bus.ml_raw !== 256'h0) begin errors++; $display("FAIL reset_ml_raw got=%h exp=0", bus.ml_raw); end
    checks++; if (bus.ml_mode !== sha::sha256) begin errors++; $display("FAIL reset_ml_mode got=%0d exp=%0d", bus.ml_mode, sha::sha256); end
    bus.digest_ready = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.msg_ready !== 1'b0) begin errors++; $display("FAIL idle_msg_valid_ignored got=%b exp=0", bus.msg_ready); end
    bus.msg_valid = 1'b0;
    foreach (mh[i]) mh[i] = 32'h0;
  endtask

  task automatic test_abc256();
    int lat, en;
    logic [255:0] got;
    bit st;
    set_abc();
    do_start(sha::sha256, 1'b1);
    model_block(sha::sha256, 1'b1);
    send_block(0, lat, en);
    checks++; if (lat !== 65) begin errors++; $display("FAIL abc256_latency got=%0d exp=65", lat); end
    checks++; if (en !== 64) begin errors++; $display("FAIL abc256_enable_cycles got=%0d exp=64", en); end
    recv_digest(0, got, st);
    checks++; if (got !== D_ABC256) begin errors++; $display("FAIL abc256_digest got=%h exp=%h", got, D_ABC256); end
    checks++; if (got !== model_digest(sha::sha256)) begin errors++; $display("FAIL abc256_model got=%h exp=%h", got, model_digest(sha::sha256)); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abc256_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abc224();
    int lat, en;
    logic [255:0] got;
    bit st;
    set_abc();
    do_start(sha::sha224, 1'b1);
    model_block(sha::sha224, 1'b1);
    send_block(20, lat, en);
    checks++; if (bus.ml_mode !== sha::sha224) begin errors++; $display("FAIL abc224_ml_mode got=%0d exp=%0d", bus.ml_mode, sha::sha224); end
    recv_digest(2, got, st);
    checks++; if (got !== D_ABC224) begin errors++; $display("FAIL abc224_digest got=%h exp=%h", got, D_ABC224); end
    checks++; if (got !== model_digest(sha::sha224)) begin errors++; $display("FAIL abc224_model got=%h exp=%h", got, model_digest(sha::sha224)); end
  endtask

  task automatic test_two_block();
    int lat, en;
    logic [255:0] got;
    bit st;
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    do_start(sha::sha256, 1'b1);
    model_block(sha::sha256, 1'b1);
    send_block(40, lat, en);
    recv_digest($urandom_range(1, 6), got, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL two_block_b1_stable got=%b exp=1", st); end
    checks++; if (got !== model_digest(sha::sha256)) begin errors++; $display("FAIL two_block_b1_model got=%h exp=%h", got, model_digest(sha::sha256)); end
    foreach (blk[i]) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
    do_start(sha::sha256, 1'b0);
    model_block(sha::sha256, 1'b0);
    send_block(40, lat, en);
    recv_digest($urandom_range(3, 8), got, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL two_block_b2_stable got=%b exp=1", st); end
    checks++; if (got !== D_TWO) begin errors++; $display("FAIL two_block_digest got=%h exp=%h", got, D_TWO); end
  endtask

  task automatic test_empty();
    int lat, en;
    logic [255:0] got;
    bit st;
    foreach (blk[i]) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
    do_start(sha::sha256, 1'b1);
    model_block(sha::sha256, 1'b1);
    send_block(0, lat, en);
    checks++; if (en !== 64) begin errors++; $display("FAIL empty_enable_cycles got=%0d exp=64", en); end
    recv_digest(0, got, st);
    checks++; if (got !== D_EMPTY) begin errors++; $display("FAIL empty_digest got=%h exp=%h", got, D_EMPTY); end
  endtask

  task automatic test_bad_mode();
    @(negedge clk);
    bus.start = 1'b1; bus.init = 1'b1; bus.mode = sha::sha512;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_mode_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bad_mode_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bad_mode_err_pulse got=%b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bad_mode_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_start_during_round();
    int lat, en;
    logic [255:0] got;
    bit st;
    bit err_seen;
    foreach (blk[i]) blk[i] = $urandom;
    do_start(sha::sha256, 1'b1);
    model_block(sha::sha256, 1'b1);
    err_seen = 1'b0;
    fork
      send_block(10, lat, en);
      begin
        int n;
        n = 0;
        while (!bus.ml_enable && n < 500) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.init = 1'b1; bus.mode = sha::sha224;
        bus.msg_valid = 1'b1; bus.msg_data = $urandom;
        @(negedge clk);
        bus.mode = sha::sha512;
        @(negedge clk);
        if (bus.err) err_seen = 1'b1;
        bus.start = 1'b0; bus.msg_valid = 1'b0;
        @(negedge clk);
        if (bus.err) err_seen = 1'b1;
      end
    join
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL busy_start_err got=%b exp=0", err_seen); end
    recv_digest(1, got, st);
    checks++; if (got !== model_digest(sha::sha256)) begin errors++; $display("FAIL busy_start_digest got=%h exp=%h", got, model_digest(sha::sha256)); end
  endtask

  task automatic test_random_blocks();
    int lat, en;
    logic [255:0] got;
    bit st;
    sha::mode_t m;
    bit ini;
    for (int b = 0; b < 4; b++) begin
      foreach (blk[i]) blk[i] = $urandom;
      m = ($urandom_range(0, 1) == 0) ? sha::sha224 : sha::sha256;
      ini = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      do_start(m, ini);
      model_block(m, ini);
      send_block($urandom_range(0, 50), lat, en);
      checks++; if (lat !== 65) begin errors++; $display("FAIL random_latency[%0d] got=%0d exp=65", b, lat); end
      recv_digest($urandom_range(0, 4), got, st);
      checks++; if (got !== model_digest(m)) begin errors++; $display("FAIL random_digest[%0d] got=%h exp=%h", b, got, model_digest(m)); end
    end
  endtask

  task automatic test_reset_mid_round();
    int lat, en;
    logic [255:0] got;
    bit st;
    set_abc();
    do_start(sha::sha256, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.msg_valid = 1'b1; bus.msg_data = blk[k];
      @(posedge clk);
    end
    @(negedge clk);
    bus.msg_valid = 1'b0;
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if ({bus.err, bus.busy, bus.msg_ready, bus.ml_enable, bus.digest_valid} !== 5'b0) begin
      errors++; $display("FAIL midreset_ctrl got=%b exp=00000", {bus.err, bus.busy, bus.msg_ready, bus.ml_enable, bus.digest_valid}); end
    checks++; if (bus.digest !== 256'h0) begin errors++; $display("FAIL midreset_digest got=%h exp=0", bus.digest); end
    checks++; if ({bus.ml_w, bus.ml_k} !== 64'h0) begin errors++; $display("FAIL midreset_w_k got=%h exp=0", {bus.ml_w, bus.ml_k}); end
    checks++; if (bus.ml_raw !== 256'h0) begin errors++; $display("FAIL midreset_ml_raw got=%h exp=0", bus.ml_raw); end
    checks++; if (bus.ml_mode !== sha::sha256) begin errors++; $display("FAIL midreset_ml_mode got=%0d exp=%0d", bus.ml_mode, sha::sha256); end
    rstn = 1'b1;
    foreach (mh[i]) mh[i] = 32'h0;
    do_start(sha::sha256, 1'b1);
    model_block(sha::sha256, 1'b1);
    send_block(0, lat, en);
    recv_digest(0, got, st);
    checks++; if (got !== D_ABC256) begin errors++; $display("FAIL midreset_abc_digest got=%h exp=%h", got, D_ABC256); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.init = 1'b0;
    bus.mode = sha::sha256;
    bus.msg_valid = 1'b0;
    bus.msg_data = 32'h0;
    bus.digest_ready = 1'b0;
    test_reset();
    test_abc256();
    test_abc224();
    test_two_block();
    test_empty();
    test_bad_mode();
    test_start_during_round();
    test_random_blocks();
    test_reset_mid_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
